adc_spi_frame_capture: RTL and testbench
========================================

// Module: adc_spi_frame_capture
// PURPOSE
//   SPI master capture stage for the ADS131M08, directly upstream of the frame unpacker.
//   Waits for DRDY, clocks one full frame (STATUS, CH0..CH7, CRC) off MISO MSB-first, and
//   packs each word into a 32-bit slot of frame_words_packed. Pulses frame_valid when a
//   complete frame is published. SPI mode 1: SCLK idles low and MISO is sampled on the SCLK falling edge.
// PARAMETERS
//   BITS_PER_WORD    24  bits per ADC word on the wire; 1..32 ($fatal otherwise)
//   WORDS_PER_FRAME  10  words per frame; >= 9 ($fatal otherwise)
//   SCLK_DIV         4   SCLK half-period in clk cycles; >= 1 ($fatal otherwise)
// PORTS
//   clk                 in   1                  system clock
//   rst_n               in   1                  async active-low reset
//   enable              in   1                  1 = arm on DRDY; 0 = ignore DRDY
//   adc_drdy_n          in   1                  ADC data-ready, async, falling edge = new frame
//   adc_miso            in   1                  ADC serial data out
//   adc_cs_n            out  1                  chip select, active low
//   adc_sclk            out  1                  serial clock
//   adc_mosi            out  1                  held 0 (NULL command)
//   frame_words_packed  out  32*WORDS_PER_FRAME word k in [32k+31:32k]
//   frame_valid         out  1                  1-cycle pulse: new frame published
//   busy                out  1                  high from CS_SETUP through DONE
//   overrun             out  1                  sticky: DRDY fell while busy
//   clear_overrun       in   1                  synchronous clear of overrun
// BEHAVIOUR
// - Reset values: adc_cs_n=1, adc_sclk=0, adc_mosi=0, frame_words_packed=0, frame_valid=0,
//   busy=0, overrun=0, FSM=IDLE. Reset mid-frame aborts immediately. No partial frame is published.
// - DRDY handling: adc_drdy_n passes through a 2-flop synchroniser (reset value 1).
//   drdy_fall = 1 when the previous synced value is 1 and the current synced value is 0.
// - FSM IDLE -> CS_SETUP -> SHIFT -> CS_HOLD -> DONE -> IDLE.
//   IDLE: on drdy_fall && enable, go to CS_SETUP. Call that cycle T0.
//   CS_SETUP: cs_n=0 from T0+1; lasts SCLK_DIV cycles.
//   SHIFT: N = BITS_PER_WORD*WORDS_PER_FRAME bits. Per bit, SCLK is high for SCLK_DIV cycles,
//     then low for SCLK_DIV cycles. adc_miso is registered in the cycle SCLK goes 1->0.
//   CS_HOLD: SCLK=0, cs_n=0; lasts SCLK_DIV cycles. cs_n returns to 1 on entering DONE.
//   DONE: one cycle. frame_words_packed is loaded from the shadow buffer and frame_valid=1,
//     so frame_valid is high at T0+1+SCLK_DIV*(2N+2).
// - Word packing: bits shift into a BITS_PER_WORD shifter. After BITS_PER_WORD samples the
//   shifter writes shadow slot k as {zero-pad, word}; upper 32-BITS_PER_WORD bits are 0.
//   Sign extension belongs downstream. Word 0 is the first word on the wire (STATUS).
//   Counters: bit_cnt 0..BITS_PER_WORD-1 and word_cnt 0..WORDS_PER_FRAME-1 both wrap to 0.
//   SHIFT exits when word_cnt==WORDS_PER_FRAME-1 and bit_cnt==BITS_PER_WORD-1 have been sampled.
// - Output stability: frame_words_packed changes only in DONE and is otherwise held
//   (atomic publish), so consumers may read it at any time.
// - Overrun: drdy_fall while FSM != IDLE sets overrun and the edge is dropped; the current
//   frame completes normally. If set and clear_overrun occur in the same cycle, set wins.
// - enable deasserted mid-frame: the frame completes and is published; no new frame starts.
// - enable=0 in IDLE: DRDY edges are ignored and overrun is not set.
// - A drdy_fall in the DONE cycle counts as an overrun and does not start a frame.
// STRUCTURE
// - Package adc_pkg holds: ADS_WORDS_PER_FRAME=10, ADS_NUM_CH=8, ADS_STATUS_IDX=0,
//   ADS_CRC_IDX=9, and the FSM state enum typedef adc_cap_state_t.
// - Sub-module adc_drdy_sync holds the 2-flop synchroniser, falling-edge detect and async reset.
//   Everything else stays in this module.
// TESTING  (BITS_PER_WORD=24, WORDS_PER_FRAME=10, SCLK_DIV=2 unless noted; ADC BFM drives MISO on SCLK rise)
// 1. BFM word k = 24'hA00000+k, one DRDY fall. Expect 240 SCLK falls with cs_n low throughout,
//    slot k = 32'h00A0000k, one frame_valid pulse at T0+1+2*482, and busy cleared next cycle.
// 2. CH0 = 24'hFFFFFE, CH7 = 24'h800000. Expect slot1 = 32'h00FFFFFE and slot8 = 32'h00800000
//    (zero-padded). Chaining adc_soc_frame_unpack gives ch0 = -2 and ch7 = 32'hFF800000.
// 3. Second DRDY fall mid-SHIFT. Expect overrun=1, frame 1 intact with exactly 1 frame_valid,
//    and no second frame. Then clear_overrun=1 gives overrun=0 next cycle; set+clear in the
//    same cycle leaves overrun=1.
// 4. rst_n low at bit 100. Expect cs_n=1 and sclk=0 asynchronously, packed=0, no frame_valid.
//    A following DRDY fall yields a clean frame identical to scenario 1.
// 5. enable=0 plus DRDY fall: no cs_n activity, overrun=0. enable dropped mid-frame: that frame
//    is published, and the next DRDY fall is ignored.
// 6. SCLK_DIV=1, BITS_PER_WORD=32, back-to-back DRDY spaced 2N+8 cycles. Every frame is
//    captured, frame_valid count equals DRDY count, and each SCLK high/low phase is 1 cycle.

Source files
------------

// File: rtl/adc_pkg.sv
// Shared constants and FSM state type for the ADS131M08 SPI frame capture path.
package adc_pkg;

    localparam int ADS_WORDS_PER_FRAME = 10;
    localparam int ADS_NUM_CH          = 8;
    localparam int ADS_STATUS_IDX      = 0;
    localparam int ADS_CRC_IDX         = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_SHIFT,
        ST_CS_HOLD,
        ST_DONE
    } adc_cap_state_t;

endpackage

// File: rtl/adc_spi_frame_capture_if.sv
// SPI pin bundle between the capture master and the ADC.
interface adc_spi_frame_capture_if;

    logic adc_drdy_n;
    logic adc_miso;
    logic adc_cs_n;
    logic adc_sclk;
    logic adc_mosi;

    modport master (
        input  adc_drdy_n,
        input  adc_miso,
        output adc_cs_n,
        output adc_sclk,
        output adc_mosi
    );

    modport slave (
        output adc_drdy_n,
        output adc_miso,
        input  adc_cs_n,
        input  adc_sclk,
        input  adc_mosi
    );

endinterface

// File: rtl/adc_drdy_sync.sv
// Two-flop synchroniser for the async DRDY line plus a falling-edge detector.
module adc_drdy_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic drdy_n_i,
    output logic drdy_fall_o
);

    // [1:0] synchronise, [2] holds the previous synchronised value
    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b111;
        end else begin
            sync_q <= {sync_q[1:0], drdy_n_i};
        end
    end

    assign drdy_fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/adc_spi_frame_capture.sv
// SPI mode-1 master: on DRDY fall, clocks one ADS131M08 frame in MSB-first and
// publishes it atomically as zero-padded 32-bit slots with a one-cycle frame_valid.
module adc_spi_frame_capture
    import adc_pkg::*;
#(
    parameter int BITS_PER_WORD   = 24,
    parameter int WORDS_PER_FRAME = ADS_WORDS_PER_FRAME,
    parameter int SCLK_DIV        = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            clear_overrun,
    adc_spi_frame_capture_if.master         spi,
    output logic [32*WORDS_PER_FRAME-1:0]   frame_words_packed,
    output logic                            frame_valid,
    output logic                            busy,
    output logic                            overrun
);

    if (BITS_PER_WORD < 1 || BITS_PER_WORD > 32) begin : g_bad_bpw
        $fatal(1, "BITS_PER_WORD must be 1..32");
    end
    if (WORDS_PER_FRAME < ADS_NUM_CH + 1) begin : g_bad_wpf
        $fatal(1, "WORDS_PER_FRAME must be >= 9");
    end
    if (SCLK_DIV < 1) begin : g_bad_div
        $fatal(1, "SCLK_DIV must be >= 1");
    end

    localparam int BC_W = $clog2(BITS_PER_WORD + 1);
    localparam int WC_W = $clog2(WORDS_PER_FRAME + 1);
    localparam int DV_W = $clog2(SCLK_DIV + 1);
    localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(BITS_PER_WORD - 1);
    localparam logic [WC_W-1:0] WORD_LAST = WC_W'(WORDS_PER_FRAME - 1);
    localparam logic [DV_W-1:0] DIV_LAST  = DV_W'(SCLK_DIV - 1);

    adc_cap_state_t state_q, state_d;
    logic [DV_W-1:0]                    div_q, div_d;
    logic [BC_W-1:0]                    bit_q, bit_d;
    logic [WC_W-1:0]                    word_q, word_d;
    logic                               sclk_q, sclk_d;
    logic                               last_q, last_d;
    logic                               overrun_q, overrun_d;
    logic                               cs_n_q;
    logic                               fv_q;
    logic [BITS_PER_WORD-1:0]           shift_q, shift_d, shift_nx;
    logic [WORDS_PER_FRAME-1:0][31:0]   shadow_q, shadow_d, packed_q;
    logic                               drdy_fall;
    logic                               div_end;

    adc_drdy_sync u_drdy_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .drdy_n_i    (spi.adc_drdy_n),
        .drdy_fall_o (drdy_fall)
    );

    assign div_end  = (div_q == DIV_LAST);
    assign shift_nx = BITS_PER_WORD'({shift_q, spi.adc_miso});

    always_comb begin
        state_d  = state_q;
        div_d    = '0;
        sclk_d   = sclk_q;
        bit_d    = bit_q;
        word_d   = word_q;
        last_d   = last_q;
        shift_d  = shift_q;
        shadow_d = shadow_q;

        if (state_q inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD}) begin
            div_d = div_end ? '0 : div_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (drdy_fall && enable) begin
                    state_d = ST_CS_SETUP;
                    bit_d   = '0;
                    word_d  = '0;
                    last_d  = 1'b0;
                end
            end
            ST_CS_SETUP: begin
                if (div_end) begin
                    state_d = ST_SHIFT;
                    sclk_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (div_end) begin
                    if (sclk_q) begin
                        // falling SCLK: MISO has been stable since the rise
                        sclk_d  = 1'b0;
                        shift_d = shift_nx;
                        if (bit_q == BIT_LAST) begin
                            bit_d = '0;
                            for (int k = 0; k < WORDS_PER_FRAME; k++) begin
                                if (word_q == WC_W'(k)) shadow_d[k] = 32'(shift_nx);
                            end
                            if (word_q == WORD_LAST) begin
                                word_d = '0;
                                last_d = 1'b1;
                            end else begin
                                word_d = word_q + 1'b1;
                            end
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else if (last_q) begin
                        // low half of the final bit is done
                        state_d = ST_CS_HOLD;
                        last_d  = 1'b0;
                    end else begin
                        sclk_d = 1'b1;
                    end
                end
            end
            ST_CS_HOLD: begin
                if (div_end) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // an edge while a frame is in flight is dropped; a set beats a same-cycle clear
    always_comb begin
        overrun_d = overrun_q;
        if (drdy_fall && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end else if (clear_overrun) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            sclk_q    <= 1'b0;
            bit_q     <= '0;
            word_q    <= '0;
            last_q    <= 1'b0;
            shift_q   <= '0;
            shadow_q  <= '0;
            packed_q  <= '0;
            cs_n_q    <= 1'b1;
            fv_q      <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            sclk_q    <= sclk_d;
            bit_q     <= bit_d;
            word_q    <= word_d;
            last_q    <= last_d;
            shift_q   <= shift_d;
            shadow_q  <= shadow_d;
            cs_n_q    <= !(state_d inside {ST_CS_SETUP, ST_SHIFT, ST_CS_HOLD});
            fv_q      <= (state_d == ST_DONE);
            overrun_q <= overrun_d;
            if (state_d == ST_DONE) packed_q <= shadow_q;
        end
    end

    assign spi.adc_cs_n       = cs_n_q;
    assign spi.adc_sclk       = sclk_q;
    assign spi.adc_mosi       = 1'b0;
    assign frame_words_packed = packed_q;
    assign frame_valid        = fv_q;
    assign busy               = (state_q != ST_IDLE);
    assign overrun            = overrun_q;

endmodule

// File: tb/tb_adc_spi_frame_capture.sv
// Directed bench: DUT A at 24b/10w/div2, DUT B at 32b/10w/div1 for back-to-back frames.
module tb_adc_spi_frame_capture;
    import adc_pkg::*;

    localparam int BPW   = 24;
    localparam int WPF   = 10;
    localparam int DIV   = 2;
    localparam int BPW_B = 32;
    localparam int DIV_B = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic en_a, clr_a, fv_a, busy_a, ovr_a;
    logic en_b, clr_b, fv_b, busy_b, ovr_b;
    logic [32*WPF-1:0] packed_a, packed_b;

    adc_spi_frame_capture_if spi_a ();
    adc_spi_frame_capture_if spi_b ();

    adc_spi_frame_capture #(.BITS_PER_WORD(BPW), .WORDS_PER_FRAME(WPF), .SCLK_DIV(DIV)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .enable(en_a), .clear_overrun(clr_a), .spi(spi_a.master),
        .frame_words_packed(packed_a), .frame_valid(fv_a), .busy(busy_a), .overrun(ovr_a));

    adc_spi_frame_capture #(.BITS_PER_WORD(BPW_B), .WORDS_PER_FRAME(WPF), .SCLK_DIV(DIV_B)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .enable(en_b), .clear_overrun(clr_b), .spi(spi_b.master),
        .frame_words_packed(packed_b), .frame_valid(fv_b), .busy(busy_b), .overrun(ovr_b));

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ADC models: shift the next bit out on every SCLK rise, restart on CS fall
    logic [31:0] words_a [WPF];
    logic [31:0] words_b [WPF];
    int idx_a = 0, idx_b = 0, csfall_a = 0, falls_a = 0, csbad_a = 0;

    always @(negedge spi_a.adc_cs_n) begin idx_a = 0; csfall_a++; end
    always @(posedge spi_a.adc_sclk) begin
        if (idx_a < BPW*WPF) spi_a.adc_miso = words_a[idx_a / BPW][BPW-1 - idx_a % BPW];
        idx_a++;
    end
    always @(negedge spi_a.adc_sclk) begin
        falls_a++;
        if (spi_a.adc_cs_n === 1'b1) csbad_a++;
    end

    always @(negedge spi_b.adc_cs_n) idx_b = 0;
    always @(posedge spi_b.adc_sclk) begin
        if (idx_b < BPW_B*WPF) spi_b.adc_miso = words_b[idx_b / BPW_B][BPW_B-1 - idx_b % BPW_B];
        idx_b++;
    end

    int fvcnt_a = 0, fvcnt_b = 0, hi_b = 0, perr_b = 0, last_rise_b = 0;
    bit have_rise_b = 1'b0;
    logic prev_sclk_b = 1'b0;
    always @(negedge clk) begin
        if (fv_a === 1'b1) fvcnt_a++;
        if (fv_b === 1'b1) fvcnt_b++;
        if (spi_b.adc_cs_n === 1'b0 && spi_b.adc_sclk === 1'b1) hi_b++;
        if (spi_b.adc_sclk === 1'b1 && prev_sclk_b === 1'b0) begin
            if (have_rise_b && (cyc - last_rise_b) != 2) perr_b++;
            last_rise_b = cyc;
            have_rise_b = 1'b1;
        end
        if (spi_b.adc_sclk === 1'b1 && prev_sclk_b === 1'b1) perr_b++;
        if (spi_b.adc_cs_n !== 1'b0) have_rise_b = 1'b0;
        prev_sclk_b = spi_b.adc_sclk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input bit sel_b, output int c);
        @(negedge clk);
        c = cyc;
        if (sel_b) spi_b.adc_drdy_n = 1'b0; else spi_a.adc_drdy_n = 1'b0;
        repeat (4) @(negedge clk);
        if (sel_b) spi_b.adc_drdy_n = 1'b1; else spi_a.adc_drdy_n = 1'b1;
    endtask

    task automatic wait_fv_a(input string tag, input int bound, output int c);
        c = -1;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (fv_a === 1'b1) begin c = cyc; break; end
        end
        n_vec++;
        assert (c >= 0) else begin
            n_bad++;
            $error("FAIL %s: observed no frame_valid in %0d cycles expected one", tag, bound);
        end
    endtask

    task automatic chk_slots_a1(input string tag);
        for (int k = 0; k < WPF; k++)
            chk($sformatf("%s_slot%0d", tag, k), packed_a[k*32 +: 32], 32'h00A00000 + k);
    endtask

    int c, c2, fc, f0, s0, s1, s2;

    initial begin
        en_a = 1'b1; clr_a = 1'b0; en_b = 1'b1; clr_b = 1'b0;
        spi_a.adc_drdy_n = 1'b1; spi_b.adc_drdy_n = 1'b1;
        spi_a.adc_miso = 1'b0; spi_b.adc_miso = 1'b0;
        for (int k = 0; k < WPF; k++) begin
            words_a[k] = 32'hFFA00000 + k;        // upper byte must never reach a slot
            words_b[k] = 32'hC0DE0000 + k * 32'h00011111;
        end
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_cs_n", spi_a.adc_cs_n, 1);
        chk("rst_sclk", spi_a.adc_sclk, 0);
        chk("rst_mosi", spi_a.adc_mosi, 0);
        chk("rst_status", packed_a[ADS_STATUS_IDX*32 +: 32], 0);
        chk("rst_crc", packed_a[ADS_CRC_IDX*32 +: 32], 0);
        chk("rst_fv", fv_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_ovr", ovr_a, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 1: basic frame and timing
        f0 = fvcnt_a; s0 = falls_a; s1 = csbad_a;
        pulse(1'b0, c);
        wait_fv_a("s1_fv", 1200, fc);
        chk("s1_fv_cycle", fc - c, 967);
        chk("s1_busy_done", busy_a, 1);
        chk_slots_a1("s1");
        @(negedge clk);
        chk("s1_busy_after", busy_a, 0);
        chk("s1_sclk_falls", falls_a - s0, 240);
        chk("s1_cs_high_at_fall", csbad_a - s1, 0);
        chk("s1_fv_count", fvcnt_a - f0, 1);
        chk("s1_ovr", ovr_a, 0);

        // 2: negative-looking words stay zero-padded; output held mid-frame
        words_a[1] = 32'hEEFFFFFE;
        words_a[8] = 32'h77800000;
        pulse(1'b0, c);
        repeat (300) @(negedge clk);
        chk("s2_hold_slot1", packed_a[32 +: 32], 32'h00A00001);
        wait_fv_a("s2_fv", 1000, fc);
        chk("s2_ch0", packed_a[32 +: 32], 32'h00FFFFFE);
        chk("s2_ch7", packed_a[8*32 +: 32], 32'h00800000);
        chk("s2_status", packed_a[0 +: 32], 32'h00A00000);
        chk("s2_crc", packed_a[9*32 +: 32], 32'h00A00009);
        words_a[1] = 32'hFFA00001;
        words_a[8] = 32'hFFA00008;

        // 3: overrun during SHIFT, clear, and set-beats-clear
        repeat (5) @(negedge clk);
        f0 = fvcnt_a;
        pulse(1'b0, c);
        repeat (300) @(negedge clk);
        pulse(1'b0, c2);
        repeat (3) @(negedge clk);
        chk("s3_ovr_set", ovr_a, 1);
        wait_fv_a("s3_fv", 1000, fc);
        chk("s3_fv_cycle", fc - c, 967);
        chk_slots_a1("s3");
        repeat (1100) @(negedge clk);
        chk("s3_fv_count", fvcnt_a - f0, 1);
        chk("s3_idle", busy_a, 0);
        chk("s3_ovr_sticky", ovr_a, 1);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("s3_ovr_cleared", ovr_a, 0);
        pulse(1'b0, c);
        repeat (100) @(negedge clk);
        spi_a.adc_drdy_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        chk("s3_set_wins", ovr_a, 1);
        repeat (3) @(negedge clk);
        spi_a.adc_drdy_n = 1'b1;
        wait_fv_a("s3b_fv", 1000, fc);
        @(negedge clk);
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;

        // 4: reset at bit 100
        repeat (5) @(negedge clk);
        f0 = fvcnt_a; s0 = falls_a;
        pulse(1'b0, c);
        for (int i = 0; i < 1000 && (falls_a - s0) < 100; i++) @(negedge clk);
        chk("s4_reached_bit100", (falls_a - s0) >= 100, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("s4_async_cs_n", spi_a.adc_cs_n, 1);
        chk("s4_async_sclk", spi_a.adc_sclk, 0);
        chk("s4_busy", busy_a, 0);
        chk("s4_packed0", packed_a[0 +: 32], 0);
        chk("s4_packed1", packed_a[32 +: 32], 0);
        chk("s4_fv", fv_a, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("s4_no_fv", fvcnt_a - f0, 0);
        pulse(1'b0, c);
        wait_fv_a("s4_fv", 1200, fc);
        chk("s4_fv_cycle", fc - c, 967);
        chk_slots_a1("s4");

        // 5: enable gating
        repeat (5) @(negedge clk);
        f0 = fvcnt_a; s2 = csfall_a;
        en_a = 1'b0;
        pulse(1'b0, c);
        repeat (50) @(negedge clk);
        chk("s5_no_cs", csfall_a - s2, 0);
        chk("s5_busy", busy_a, 0);
        chk("s5_ovr", ovr_a, 0);
        en_a = 1'b1;
        words_a[5] = 32'h00123456;
        pulse(1'b0, c);
        repeat (200) @(negedge clk);
        en_a = 1'b0;
        wait_fv_a("s5_fv", 1000, fc);
        chk("s5_slot5", packed_a[5*32 +: 32], 32'h00123456);
        chk("s5_slot4", packed_a[4*32 +: 32], 32'h00A00004);
        @(negedge clk);
        pulse(1'b0, c);
        repeat (1100) @(negedge clk);
        chk("s5_fv_count", fvcnt_a - f0, 1);
        chk("s5_cs_count", csfall_a - s2, 1);
        chk("s5_ovr_after", ovr_a, 0);

        // 6: DUT B, div 1, 32-bit words, DRDY every 2N+8 cycles
        f0 = fvcnt_b; s0 = hi_b; s1 = perr_b;
        for (int i = 0; i < 3; i++) begin
            pulse(1'b1, c);
            repeat (648 - 5) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("s6_fv_count", fvcnt_b - f0, 3);
        chk("s6_sclk_high_cycles", hi_b - s0, 3 * 320);
        chk("s6_phase_err", perr_b - s1, 0);
        chk("s6_ovr", ovr_b, 0);
        for (int k = 0; k < WPF; k++)
            chk($sformatf("s6_slot%0d", k), packed_b[k*32 +: 32], 32'hC0DE0000 + k * 32'h00011111);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
